// File: rtl/dec_pkg.sv
// Shared types and helpers for the sequential one-hot decoder.
// Select widths up to MAX_SEL_W are supported by onehot_of().
package dec_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StScan
    } dec_state_e;

    localparam int unsigned MAX_SEL_W = 8;
    localparam int unsigned MAX_OUT_W = 32'd1 << MAX_SEL_W;

    function automatic int unsigned out_w_of(input int unsigned sel_w);
        return 32'd1 << sel_w;
    endfunction

    // Callers size-cast the result down to their own OUT_W.
    function automatic logic [MAX_OUT_W-1:0] onehot_of(input int unsigned idx);
        return MAX_OUT_W'(1) << idx;
    endfunction

endpackage

// File: rtl/dec_dwell_timer.sv
// Dwell counter for scan mode: load latches the dwell value and clears the count,
// tc flags the last cycle of the current line's dwell.
module dec_dwell_timer
    import dec_pkg::*;
#(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic               run,
    input  logic [DWELL_W-1:0] dwell,
    output logic               tc
);

    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    assign tc = (cnt_q == dwell_q);

    always_comb begin
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        if (load) begin
            cnt_d   = '0;
            dwell_d = dwell;
        end else if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tc ? '0 : cnt_q + DWELL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            dwell_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
        end
    end

endmodule

// File: rtl/param_decoder_seq.sv
// Registered N-to-2^N one-hot decoder with valid/ready input and an auto-scan mode.
// Define DEC_ONEHOT_CHECK_EN to add the sticky onehot_err output and its assertion.
module param_decoder_seq
    import dec_pkg::*;
#(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned DWELL_W = 4,
    parameter bit          ACT_LOW = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      en,
    input  logic [DWELL_W-1:0]        dwell,
    input  logic                      stop,
    output logic [(1 << SEL_W)-1:0]   out_lines,
    output logic                      out_valid,
    output logic [SEL_W-1:0]          cur_idx
`ifdef DEC_ONEHOT_CHECK_EN
    ,
    output logic                      onehot_err
`endif
);

    localparam int unsigned OUT_W = out_w_of(SEL_W);

    dec_state_e       state_q, state_d;
    logic [OUT_W-1:0] raw_q, raw_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;

    logic xfer;
    logic tmr_load, tmr_clear, tmr_run, tmr_tc;

    assign in_ready  = (state_q != StScan);
    assign xfer      = in_valid && in_ready;
    assign out_lines = ACT_LOW ? ~raw_q : raw_q;
    assign out_valid = valid_q;
    assign cur_idx   = idx_q;

    dec_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .clear (tmr_clear),
        .run   (tmr_run),
        .dwell (dwell),
        .tc    (tmr_tc)
    );

    always_comb begin
        state_d   = state_q;
        raw_d     = raw_q;
        idx_d     = idx_q;
        valid_d   = 1'b0;
        tmr_load  = 1'b0;
        tmr_clear = 1'b0;
        tmr_run   = 1'b0;
        unique case (state_q)
            StIdle, StHold: begin
                if (xfer) begin
                    idx_d   = sel;
                    valid_d = 1'b1;
                    if (mode) begin
                        // en has no effect on a scan start.
                        raw_d    = OUT_W'(onehot_of(32'(sel)));
                        tmr_load = 1'b1;
                        state_d  = StScan;
                    end else begin
                        raw_d   = en ? OUT_W'(onehot_of(32'(sel))) : '0;
                        state_d = StHold;
                    end
                end
            end
            StScan: begin
                // stop beats a coincident advance.
                if (stop) begin
                    raw_d     = '0;
                    valid_d   = 1'b1;
                    tmr_clear = 1'b1;
                    state_d   = StIdle;
                end else begin
                    tmr_run = 1'b1;
                    if (tmr_tc) begin
                        idx_d   = idx_q + SEL_W'(1);
                        raw_d   = OUT_W'(onehot_of(32'(idx_d)));
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            raw_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            raw_q   <= raw_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

`ifdef DEC_ONEHOT_CHECK_EN
    logic multi_hot;
    logic err_q;

    assign multi_hot  = |(raw_q & (raw_q - OUT_W'(1)));
    assign onehot_err = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (multi_hot) begin
            err_q <= 1'b1;
        end
    end

    a_raw_onehot: assert property (@(posedge clk) disable iff (rst) !multi_hot)
        else $error("param_decoder_seq: raw output has more than one line set");
`else
    // Without the checker the register image is trusted as one-hot by construction.
`endif

endmodule

// File: tb/tb_param_decoder_seq.sv
// Scoreboard bench for param_decoder_seq: every expected output update is queued
// with its cycle when stimulus is driven and matched against each out_valid pulse.
module tb_param_decoder_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       in_valid;
    logic       en;
    logic       stop;
    logic [1:0] sel;
    logic [3:0] dwell;

    logic       in_ready, out_valid;
    logic [3:0] out_lines;
    logic [1:0] cur_idx;
    logic       lo_in_ready, lo_out_valid;
    logic [3:0] lo_lines;
    logic [1:0] lo_idx;
`ifdef DEC_ONEHOT_CHECK_EN
    logic       onehot_err, lo_onehot_err;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] lines;
        logic [1:0] idx;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    param_decoder_seq #(
        .SEL_W   (2),
        .DWELL_W (4),
        .ACT_LOW (1'b0)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sel        (sel),
        .en         (en),
        .dwell      (dwell),
        .stop       (stop),
        .out_lines  (out_lines),
        .out_valid  (out_valid),
        .cur_idx    (cur_idx)
`ifdef DEC_ONEHOT_CHECK_EN
        ,
        .onehot_err (onehot_err)
`endif
    );

    param_decoder_seq #(
        .SEL_W   (2),
        .DWELL_W (4),
        .ACT_LOW (1'b1)
    ) u_dut_lo (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (lo_in_ready),
        .sel        (sel),
        .en         (en),
        .dwell      (dwell),
        .stop       (stop),
        .out_lines  (lo_lines),
        .out_valid  (lo_out_valid),
        .cur_idx    (lo_idx)
`ifdef DEC_ONEHOT_CHECK_EN
        ,
        .onehot_err (lo_onehot_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [3:0] lines, input logic [1:0] idx);
        exp_t e;
        e.cyc   = c;
        e.lines = lines;
        e.idx   = idx;
        sb.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Output monitor: every update pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
                exp_t       e;
                logic [3:0] inv;
                e   = sb.pop_front();
                inv = ~e.lines;
                check("upd_cycle", cyc, e.cyc);
                check("upd_lines", 32'(out_lines), 32'(e.lines));
                check("upd_idx", 32'(cur_idx), 32'(e.idx));
                check("upd_lines_act_low", 32'(lo_lines), 32'(inv));
                check("upd_valid_act_low", 32'(lo_out_valid), 32'd1);
            end
        end
    end

    initial begin
        int c;
        rst      = 1'b1;
        in_valid = 1'b0;
        mode     = 1'b0;
        en       = 1'b0;
        stop     = 1'b0;
        sel      = '0;
        dwell    = '0;
        step();
        step();
        rst = 1'b0;

        check("rst_lines", 32'(out_lines), 32'h0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_idx", 32'(cur_idx), 32'd0);
        check("rst_lines_act_low", 32'(lo_lines), 32'hF);

        // Direct decode sweep, back to back.
        for (int s = 0; s < 4; s++) begin
            in_valid = 1'b1;
            mode     = 1'b0;
            en       = 1'b1;
            sel      = 2'(s);
            push(cyc + 1, 4'(1 << s), 2'(s));
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        check("hold_lines", 32'(out_lines), 32'h8);
        check("hold_idx", 32'(cur_idx), 32'd3);
        check("hold_ready", 32'(in_ready), 32'd1);

        // Blanking request.
        in_valid = 1'b1;
        en       = 1'b0;
        sel      = 2'd2;
        push(cyc + 1, 4'h0, 2'd2);
        step();
        in_valid = 1'b0;
        step();
        check("blank_lines_act_low", 32'(lo_lines), 32'hF);

        // Scan from 2 with dwell 1; en=0 must not blank a scan.
        c        = cyc;
        in_valid = 1'b1;
        mode     = 1'b1;
        en       = 1'b0;
        sel      = 2'd2;
        dwell    = 4'd1;
        push(c + 1, 4'b0100, 2'd2);
        push(c + 3, 4'b1000, 2'd3);
        push(c + 5, 4'b0001, 2'd0);
        push(c + 7, 4'b0010, 2'd1);
        push(c + 9, 4'b0000, 2'd1);
        step();
        // A pending request during scan must be refused.
        mode = 1'b0;
        en   = 1'b1;
        sel  = 2'd0;
        while (cyc < c + 8) begin
            check("scan_ready", 32'(in_ready), 32'd0);
            step();
        end
        // Stop lands on the cycle the next advance would happen.
        in_valid = 1'b0;
        stop     = 1'b1;
        step();
        check("stop_ready", 32'(in_ready), 32'd1);
        check("stop_lines", 32'(out_lines), 32'h0);
        // stop while idle has no effect.
        repeat (2) step();
        stop = 1'b0;

        // Dwell 0 advances every cycle; stop again on an advance.
        c        = cyc;
        in_valid = 1'b1;
        mode     = 1'b1;
        sel      = 2'd3;
        dwell    = 4'd0;
        push(c + 1, 4'b1000, 2'd3);
        push(c + 2, 4'b0001, 2'd0);
        push(c + 3, 4'b0010, 2'd1);
        push(c + 4, 4'b0000, 2'd1);
        step();
        in_valid = 1'b0;
        step();
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();

        // Reset mid-scan: dwell 3, sitting on index 1.
        c        = cyc;
        in_valid = 1'b1;
        mode     = 1'b1;
        sel      = 2'd1;
        dwell    = 4'd3;
        push(c + 1, 4'b0010, 2'd1);
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("midrst_lines", 32'(out_lines), 32'h0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_idx", 32'(cur_idx), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_lines_act_low", 32'(lo_lines), 32'hF);
        rst = 1'b0;
        step();

        // Direct decode works again from idle.
        in_valid = 1'b1;
        mode     = 1'b0;
        en       = 1'b1;
        sel      = 2'd1;
        push(cyc + 1, 4'b0010, 2'd1);
        step();
        in_valid = 1'b0;
        repeat (6) step();

        check("sb_drained", sb.size(), 32'd0);
`ifdef DEC_ONEHOT_CHECK_EN
        check("onehot_err", 32'(onehot_err), 32'd0);
        check("onehot_err_act_low", 32'(lo_onehot_err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
